// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receiver.
// UART_RX_PARITY_EN adds the parity state to the state enum.
package uart_pkg;

   localparam int unsigned DATA_BITS_MIN  = 5;
   localparam int unsigned DATA_BITS_MAX  = 9;
   localparam int unsigned OVERSAMPLE_MIN = 8;
   localparam int unsigned OVERSAMPLE_MAX = 32;
   localparam int unsigned STOP_BITS_MIN  = 1;
   localparam int unsigned STOP_BITS_MAX  = 2;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
`ifdef UART_RX_PARITY_EN
      StParity,
`endif
      StStop,
      StBreak
   } uart_rx_state_t;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   function automatic bit params_legal(input int unsigned data_bits,
                                       input int unsigned oversample,
                                       input int unsigned stop_bits);
      return (data_bits >= DATA_BITS_MIN) && (data_bits <= DATA_BITS_MAX) &&
             (oversample >= OVERSAMPLE_MIN) && (oversample <= OVERSAMPLE_MAX) &&
             ((oversample & (oversample - 1)) == 0) &&
             (stop_bits >= STOP_BITS_MIN) && (stop_bits <= STOP_BITS_MAX);
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Baud tick generator: one-cycle pulse every div+1 clocks, held cleared by clr.
module uart_baud_tick (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr,
   input  logic [15:0] div,
   output logic        tick
);

   logic [15:0] cnt_q;

   assign tick = !clr && (cnt_q == div);

   // Period counter restarts on every tick and whenever cleared.
   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         cnt_q <= '0;
      end else if (tick) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + 16'd1;
      end
   end

endmodule

// File: rtl/uart_rx_core.sv
// Oversampling UART receiver with majority-vote bit sampling and a one-word
// output register. Optional parity checking is enabled by UART_RX_PARITY_EN.
module uart_rx_core
   import uart_pkg::*;
#(
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned OVERSAMPLE = 16,
   parameter int unsigned STOP_BITS  = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rx_raw,
   input  logic [15:0]          baud_div,
`ifdef UART_RX_PARITY_EN
   input  logic                 parity_odd,
`endif
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 frame_err,
   output logic                 parity_err,
   output logic                 overrun,
   output logic                 busy
);

   localparam int unsigned CW = $clog2(OVERSAMPLE);
   localparam logic [CW-1:0] CNT_LO   = CW'(OVERSAMPLE / 2 - 1);
   localparam logic [CW-1:0] CNT_MID  = CW'(OVERSAMPLE / 2);
   localparam logic [CW-1:0] CNT_HI   = CW'(OVERSAMPLE / 2 + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
   localparam logic [3:0]    LAST_BIT  = 4'(DATA_BITS - 1);
   localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

   if (!params_legal(DATA_BITS, OVERSAMPLE, STOP_BITS)) begin : g_param_check
      $fatal(1, "uart_rx_core: illegal DATA_BITS/OVERSAMPLE/STOP_BITS");
   end

   uart_rx_state_t state_q, state_d;
   logic                 sync1_q, sync2_q, prev_q;
   logic [1:0]           vld_q;
   logic                 line_fall;
   logic [15:0]          div_q;
   logic                 tick;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [3:0]           bit_q, bit_d;
   logic                 stop_q, stop_d;
   logic [1:0]           samp_q, samp_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 ferr_q, ferr_d;
   logic                 maj, done;
`ifdef UART_RX_PARITY_EN
   logic                 perr_q, perr_d;
`endif

   // Synchronizer; vld_q marks when sync2_q holds real line data after reset,
   // so a line already low at reset release is not mistaken for a start edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         vld_q   <= 2'b00;
         prev_q  <= 1'b0;
      end else begin
         sync1_q <= rx_raw;
         sync2_q <= sync1_q;
         vld_q   <= {vld_q[0], 1'b1};
         prev_q  <= vld_q[1] ? sync2_q : 1'b0;
      end
   end

   assign line_fall = vld_q[1] && prev_q && !sync2_q;

   // Baud divisor is only taken while idle so a frame runs at one rate.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         div_q <= '0;
      end else if (state_q == StIdle) begin
         div_q <= baud_div;
      end
   end

   uart_baud_tick u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (state_q == StIdle),
      .div   (div_q),
      .tick  (tick)
   );

   // Frame FSM state and datapath registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         bit_q   <= '0;
         stop_q  <= 1'b0;
         samp_q  <= '0;
         shift_q <= '0;
         ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         perr_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         stop_q  <= stop_d;
         samp_q  <= samp_d;
         shift_q <= shift_d;
         ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
         perr_q  <= perr_d;
`endif
      end
   end

   // Next-state logic; all bit decisions are made at the third sample (CNT_HI).
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      stop_d  = stop_q;
      samp_d  = samp_q;
      shift_d = shift_q;
      ferr_d  = ferr_q;
`ifdef UART_RX_PARITY_EN
      perr_d  = perr_q;
`endif
      done    = 1'b0;
      maj     = maj3(samp_q[1], samp_q[0], sync2_q);
      unique case (state_q)
         StIdle: begin
            cnt_d  = '0;
            bit_d  = '0;
            stop_d = 1'b0;
            ferr_d = 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_d = 1'b0;
`endif
            if (line_fall) state_d = StStart;
         end
         StBreak: begin
            if (sync2_q) state_d = StIdle;
         end
         default: begin
            if (tick) begin
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == CNT_LO)  samp_d[1] = sync2_q;
               if (cnt_q == CNT_MID) samp_d[0] = sync2_q;
               case (state_q)
                  StStart: begin
                     if (cnt_q == CNT_HI && maj) state_d = StIdle;
                     else if (cnt_q == CNT_LAST) state_d = StData;
                  end
                  StData: begin
                     if (cnt_q == CNT_HI) shift_d = {maj, shift_q[DATA_BITS-1:1]};
                     if (cnt_q == CNT_LAST) begin
                        if (bit_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                           state_d = StParity;
`else
                           state_d = StStop;
`endif
                        end else begin
                           bit_d = bit_q + 4'd1;
                        end
                     end
                  end
`ifdef UART_RX_PARITY_EN
                  StParity: begin
                     if (cnt_q == CNT_HI) perr_d = ((^shift_q) ^ maj) != parity_odd;
                     if (cnt_q == CNT_LAST) state_d = StStop;
                  end
`endif
                  StStop: begin
                     if (cnt_q == CNT_HI) begin
                        if (!maj) ferr_d = 1'b1;
                        if (stop_q == LAST_STOP) begin
                           done    = 1'b1;
                           state_d = (ferr_d && !sync2_q) ? StBreak : StIdle;
                        end
                     end else if (cnt_q == CNT_LAST) begin
                        stop_d = 1'b1;
                     end
                  end
                  default: ;
               endcase
            end
         end
      endcase
   end

   // Output word register: load when empty or being drained, else drop and flag.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err <= 1'b0;
`endif
      end else begin
         overrun <= 1'b0;
         if (done) begin
            if (!rx_valid || rx_ready) begin
               rx_data   <= shift_q;
               frame_err <= ferr_d;
               rx_valid  <= 1'b1;
`ifdef UART_RX_PARITY_EN
               parity_err <= perr_q;
`endif
            end else begin
               overrun <= 1'b1;
            end
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
      end
   end

`ifndef UART_RX_PARITY_EN
   assign parity_err = 1'b0;
`endif

   assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: an 8N1 instance (A) and a 9-bit,
// two-stop instance (B). Parity cases are added when UART_RX_PARITY_EN is set.
`timescale 1ns/1ps
module tb_uart_rx_core;

`ifdef UART_RX_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        rx_a, rx_b;
   logic [15:0] div_a, div_b;
   logic        par_odd;
   logic        a_ready, b_ready;
   logic [7:0]  a_data;
   logic [8:0]  b_data;
   logic        a_valid, a_fe, a_pe, a_ovr, a_busy;
   logic        b_valid, b_fe, b_pe, b_ovr, b_busy;

   int n_checks = 0;
   int n_err    = 0;
   int a_vcyc   = 0;
   int b_vcyc   = 0;
   int a_ovrn   = 0;
   logic [10:0] qa[$];
   logic [10:0] qb[$];

   always #5 clk = ~clk;

   uart_rx_core #(.DATA_BITS(8), .OVERSAMPLE(16), .STOP_BITS(1)) dut_a (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx_raw     (rx_a),
      .baud_div   (div_a),
`ifdef UART_RX_PARITY_EN
      .parity_odd (par_odd),
`endif
      .rx_data    (a_data),
      .rx_valid   (a_valid),
      .rx_ready   (a_ready),
      .frame_err  (a_fe),
      .parity_err (a_pe),
      .overrun    (a_ovr),
      .busy       (a_busy)
   );

   uart_rx_core #(.DATA_BITS(9), .OVERSAMPLE(16), .STOP_BITS(2)) dut_b (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx_raw     (rx_b),
      .baud_div   (div_b),
`ifdef UART_RX_PARITY_EN
      .parity_odd (par_odd),
`endif
      .rx_data    (b_data),
      .rx_valid   (b_valid),
      .rx_ready   (b_ready),
      .frame_err  (b_fe),
      .parity_err (b_pe),
      .overrun    (b_ovr),
      .busy       (b_busy)
   );

   // Record every accepted word, valid-high cycles and overrun pulses.
   always @(negedge clk) begin
      if (rst_n) begin
         if (a_valid && a_ready) qa.push_back({a_pe, a_fe, 1'b0, a_data});
         if (a_valid) a_vcyc++;
         if (a_ovr) a_ovrn++;
         if (b_valid && b_ready) qb.push_back({b_pe, b_fe, b_data});
         if (b_valid) b_vcyc++;
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic hold(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input bit sel, input logic v);
      if (sel) rx_b = v;
      else rx_a = v;
   endtask

   // Serialize one frame; the line is left at the last stop-bit level.
   task automatic send_frame(input bit sel, input logic [8:0] data, input int nbits,
                             input int nstop, input logic [1:0] stops, input bit pflip,
                             input int bclk, input int gbit);
      logic p;
      p = 1'b0;
      drive(sel, 1'b0);
      hold(bclk);
      for (int i = 0; i < nbits; i++) begin
         p = p ^ data[i];
         drive(sel, data[i]);
         if (i == gbit) begin
            hold(9);
            drive(sel, ~data[i]);
            hold(1);
            drive(sel, data[i]);
            hold(bclk - 10);
         end else begin
            hold(bclk);
         end
      end
      if (PAR_EN) begin
         drive(sel, p ^ par_odd ^ pflip);
         hold(bclk);
      end
      for (int s = 0; s < nstop; s++) begin
         drive(sel, stops[s]);
         hold(bclk);
      end
   endtask

   task automatic expect_word(input bit sel, input string name, input logic [8:0] d,
                              input logic fe, input logic pe);
      logic [10:0] got;
      int t;
      t = 0;
      while (((sel ? qb.size() : qa.size()) == 0) && t < 3000) begin
         hold(1);
         t++;
      end
      if ((sel ? qb.size() : qa.size()) == 0) begin
         n_checks++;
         n_err++;
         $display("FAIL %s: no word delivered, expected %0h", name, d);
      end else begin
         if (sel) got = qb.pop_front();
         else got = qa.pop_front();
         check({name, " data"}, 32'(got[8:0]), 32'(d));
         check({name, " frame_err"}, 32'(got[9]), 32'(fe));
         check({name, " parity_err"}, 32'(got[10]), 32'(pe));
      end
   endtask

   typedef struct {
      bit         sel;
      logic [8:0] data;
      logic [1:0] stops;
      bit         pflip;
      int         gbit;
      logic [8:0] exp_data;
      logic       exp_fe;
      logic       exp_pe;
   } vec_t;

   vec_t vecs[10];

   initial begin
      int vc0, ov0, bclk, div, nfr;
      logic [8:0] d;
      logic [1:0] st;
      bit pf;

      vecs[0] = '{1'b0, 9'h0A5, 2'b11, 1'b0, -1, 9'h0A5, 1'b0, 1'b0};
      vecs[1] = '{1'b0, 9'h000, 2'b11, 1'b0, -1, 9'h000, 1'b0, 1'b0};
      vecs[2] = '{1'b0, 9'h0FF, 2'b11, 1'b0, -1, 9'h0FF, 1'b0, 1'b0};
      vecs[3] = '{1'b0, 9'h05A, 2'b10, 1'b0, -1, 9'h05A, 1'b1, 1'b0};
      vecs[4] = '{1'b0, 9'h081, 2'b11, 1'b1, -1, 9'h081, 1'b0, PAR_EN};
      vecs[5] = '{1'b1, 9'h1A5, 2'b11, 1'b0, -1, 9'h1A5, 1'b0, 1'b0};
      vecs[6] = '{1'b1, 9'h0F3, 2'b01, 1'b0, -1, 9'h0F3, 1'b1, 1'b0};
      vecs[7] = '{1'b1, 9'h155, 2'b10, 1'b0, -1, 9'h155, 1'b1, 1'b0};
      vecs[8] = '{1'b1, 9'h1FF, 2'b11, 1'b0,  3, 9'h1FF, 1'b0, 1'b0};
      vecs[9] = '{1'b1, 9'h000, 2'b11, 1'b0,  5, 9'h000, 1'b0, 1'b0};

      rst_n = 1'b0; rx_a = 1'b1; rx_b = 1'b1; div_a = 16'd3; div_b = 16'd0;
      par_odd = 1'b0; a_ready = 1'b1; b_ready = 1'b1;
      hold(4);
      check("reset rx_valid", 32'(a_valid), 0);
      check("reset rx_data", 32'(a_data), 0);
      check("reset frame_err", 32'(a_fe), 0);
      check("reset parity_err", 32'(a_pe), 0);
      check("reset overrun", 32'(a_ovr), 0);
      check("reset busy", 32'(a_busy), 0);
      rst_n = 1'b1;
      hold(20);

      // Table of single frames on both instances, consumer always ready.
      for (int i = 0; i < 10; i++) begin
         bclk = vecs[i].sel ? 16 : 64;
         vc0  = vecs[i].sel ? b_vcyc : a_vcyc;
         send_frame(vecs[i].sel, vecs[i].data, vecs[i].sel ? 9 : 8, vecs[i].sel ? 2 : 1,
                    vecs[i].stops, vecs[i].pflip, bclk, vecs[i].gbit);
         drive(vecs[i].sel, 1'b1);
         hold(2 * bclk);
         expect_word(vecs[i].sel, $sformatf("vec%0d", i), vecs[i].exp_data,
                     vecs[i].exp_fe, vecs[i].exp_pe);
         check($sformatf("vec%0d valid cycles", i),
               32'((vecs[i].sel ? b_vcyc : a_vcyc) - vc0), 1);
      end

      // Short low pulse on A: start rejected, nothing delivered.
      vc0 = a_vcyc;
      drive(1'b0, 1'b0);
      hold(10);
      check("glitch busy during", 32'(a_busy), 1);
      hold(10);
      drive(1'b0, 1'b1);
      hold(200);
      check("glitch busy after", 32'(a_busy), 0);
      check("glitch no word", 32'(qa.size()), 0);
      check("glitch no valid", 32'(a_vcyc - vc0), 0);

      // Frame with low stop bit followed by a long break.
      send_frame(1'b0, 9'h03C, 8, 1, 2'b00, 1'b0, 64, -1);
      hold(100);
      expect_word(1'b0, "break", 9'h03C, 1'b1, 1'b0);
      check("break busy early", 32'(a_busy), 1);
      hold(30 * 64 - 200);
      check("break busy late", 32'(a_busy), 1);
      drive(1'b0, 1'b1);
      hold(10);
      check("break busy released", 32'(a_busy), 0);
      hold(300);
      check("break no second frame", 32'(qa.size()), 0);

      // Back-to-back frames with the consumer stalled.
      a_ready = 1'b0;
      ov0 = a_ovrn;
      send_frame(1'b0, 9'h011, 8, 1, 2'b11, 1'b0, 64, -1);
      send_frame(1'b0, 9'h022, 8, 1, 2'b11, 1'b0, 64, -1);
      hold(64);
      check("overrun held data", 32'(a_data), 32'h11);
      check("overrun held valid", 32'(a_valid), 1);
      check("overrun pulses", 32'(a_ovrn - ov0), 1);
      a_ready = 1'b1;
      hold(1);
      a_ready = 1'b0;
      hold(2);
      check("overrun drained valid", 32'(a_valid), 0);
      expect_word(1'b0, "overrun word", 9'h011, 1'b0, 1'b0);
      check("overrun nothing extra", 32'(qa.size()), 0);
      a_ready = 1'b1;
      hold(20);

`ifdef UART_RX_PARITY_EN
      send_frame(1'b0, 9'h007, 8, 1, 2'b11, 1'b1, 64, -1);
      hold(64);
      expect_word(1'b0, "even parity bit0", 9'h007, 1'b0, 1'b1);
      send_frame(1'b0, 9'h007, 8, 1, 2'b11, 1'b0, 64, -1);
      hold(64);
      expect_word(1'b0, "even parity bit1", 9'h007, 1'b0, 1'b0);
      par_odd = 1'b1;
      send_frame(1'b0, 9'h007, 8, 1, 2'b11, 1'b0, 64, -1);
      hold(64);
      expect_word(1'b0, "odd parity", 9'h007, 1'b0, 1'b0);
      par_odd = 1'b0;
`endif

      // Mid-frame reset with the line still low afterwards: no reception.
      drive(1'b0, 1'b0);
      hold(100);
      rst_n = 1'b0;
      hold(3);
      rst_n = 1'b1;
      hold(300);
      check("reset abort busy", 32'(a_busy), 0);
      drive(1'b0, 1'b1);
      hold(200);
      check("reset abort no word", 32'(qa.size()), 0);
      check("reset abort no valid", 32'(a_valid), 0);

      // Random frames on A against the frame-level model.
      nfr = 24;
      vc0 = a_vcyc;
      for (int i = 0; i < nfr; i++) begin
         div   = $urandom_range(1, 3);
         div_a = 16'(div);
         bclk  = (div + 1) * 16;
         hold(8);
         d  = 9'($urandom_range(0, 255));
         st = {1'b1, 1'($urandom_range(0, 5) != 0)};
         pf = ($urandom_range(0, 3) == 0);
         send_frame(1'b0, d, 8, 1, st, pf, bclk, -1);
         drive(1'b0, 1'b1);
         hold(bclk * $urandom_range(1, 2));
         expect_word(1'b0, $sformatf("rand%0d", i), d, !st[0], PAR_EN && pf);
      end
      check("rand valid cycles", 32'(a_vcyc - vc0), 32'(nfr));

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/uart_rx_core.md
UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 Parameter DATA_BITS, default 8, meaning data bits per frame; legal values 5..9.
REQ-002 Parameter OVERSAMPLE, default 16, meaning baud ticks per bit; power of two, 8..32.
REQ-003 Parameter STOP_BITS, default 1, meaning stop bits checked per frame; legal values 1 or 2.
REQ-004 Port clk, input, 1 bit: peripheral clock.
REQ-005 Port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-006 Port rx_raw, input, 1 bit: asynchronous serial line; idle level is high.
REQ-007 Port baud_div, input, 16 bits: tick period minus one, in clk cycles; sampled only while the receiver is in IDLE.
REQ-008 Port parity_odd, input, 1 bit: 1 selects odd parity, 0 selects even; exists only with UART_RX_PARITY_EN.
REQ-009 Port rx_data, output, DATA_BITS bits: received word, LSB first on the line.
REQ-010 Port rx_valid, output, 1 bit: rx_data and its flags are valid.
REQ-011 Port rx_ready, input, 1 bit: consumer accepts the word.
REQ-012 Port frame_err, output, 1 bit: stop bit sampled low; qualified by rx_valid.
REQ-013 Port parity_err, output, 1 bit: parity mismatch; qualified by rx_valid; tied 0 without UART_RX_PARITY_EN.
REQ-014 Port overrun, output, 1 bit: one-cycle pulse when a completed frame is dropped.
REQ-015 Port busy, output, 1 bit: state is not IDLE.

Function
REQ-016 rx_raw shall pass through a 2-flop synchronizer; both flops reset to 1.
REQ-017 The tick generator shall pulse once every baud_div+1 clk cycles, and shall be held in reset while in IDLE.
REQ-018 The sample counter shall be ceil(log2(OVERSAMPLE)) bits wide, count ticks, and wrap from OVERSAMPLE-1 to 0.
REQ-019 States: IDLE, START, DATA, PARITY (only with UART_RX_PARITY_EN), STOP, BREAK.
REQ-020 In IDLE, the FSM shall go to START on the cycle the synchronized line falls 1->0; the sample counter shall clear.
REQ-021 Each bit value is the majority of 3 samples taken at counts M-1, M and M+1, where M = OVERSAMPLE/2.
REQ-022 START: if the start-bit majority is 1, the FSM shall go to IDLE with no output (glitch reject); otherwise it shall go to DATA at count OVERSAMPLE-1.
REQ-023 DATA: bits shall shift in LSB first; after bit DATA_BITS-1 at count OVERSAMPLE-1, the FSM shall go to PARITY, or to STOP if parity is not compiled in.
REQ-024 STOP: each stop bit shall be checked; frame_err is set if any stop-bit majority is 0.
REQ-025 The frame completes at count M+1 of the last stop bit (half-bit early, for back-to-back frames).
REQ-026 On completion with a clean stop, the FSM shall go to IDLE; on a framing error with the line still low, it shall go to BREAK.
REQ-027 BREAK shall wait for the synchronized line to be 1, then go to IDLE.
REQ-028 On completion, if rx_valid=0 or rx_ready=1 in that cycle, the word and flags shall load and rx_valid shall be 1 the next cycle (latency 1).
REQ-029 On completion, if rx_valid=1 and rx_ready=0, the new frame shall be dropped, the held word shall be kept, and overrun shall pulse for 1 cycle.
REQ-030 rx_valid shall clear the cycle after rx_valid&rx_ready, unless a completion loads simultaneously per REQ-028.
REQ-031 rx_data and the flags shall be stable while rx_valid=1 and rx_ready=0.

Reset
REQ-032 Reset state: FSM in IDLE, counters 0, rx_data 0, rx_valid 0, frame_err 0, parity_err 0, overrun 0, busy 0.
REQ-033 Reset asserted mid-frame shall abort the frame with no output; after reset release, reception requires a fresh falling edge.

Configuration
REQ-034 Macro UART_RX_PARITY_EN: when defined, the PARITY state exists and one parity bit follows the data, checked per parity_odd, setting parity_err on mismatch.
REQ-035 Without UART_RX_PARITY_EN: no parity_odd port, no PARITY state, and parity_err is constant 0.

Structure
REQ-036 Package uart_pkg shall hold the state enum uart_rx_state_t, the majority-of-3 function, and the parameter-legality constants.
REQ-037 Sub-module uart_baud_tick shall implement the clear-able tick generator of REQ-017.
REQ-038 Parameter legality shall be checked at elaboration with a fatal error if violated.

Verification
REQ-039 OVERSAMPLE=16, baud_div=3, frame 0xA5 8N1, rx_ready=1 -> rx_data=0xA5, rx_valid for 1 cycle, both errors 0.
REQ-040 Line low for 5 ticks, then high -> FSM returns to IDLE, rx_valid never asserts.
REQ-041 Frame 0x3C with stop bit 0, line then held low for 30 bit times -> frame_err=1 with rx_data=0x3C; busy stays 1 until line high; no second frame is produced.
REQ-042 Two back-to-back frames 0x11 and 0x22 with rx_ready=0 -> rx_data stays 0x11, overrun pulses once, and 0x11 is delivered on rx_ready.
REQ-043 With UART_RX_PARITY_EN, parity_odd=0, frame 0x07 with parity bit 0 -> parity_err=1; with parity bit 1 -> parity_err=0.
REQ-044 DATA_BITS=9, STOP_BITS=2, second stop bit 0 -> frame_err=1; a single-cycle glitch at mid-bit of a data bit is rejected by the majority vote.
